r2mdc_delay_commutator: RTL and testbench
=========================================

Name: r2mdc_delay_commutator

Overview:
One complete inter-stage reorder unit for the R2MDC FFT pipeline: pre-delays the lower butterfly path, commutates both paths with a switch period of DELAY samples, then post-delays the upper path.
- Generalises the fixed 16-bit / 32-entry pre-delay: data width and delay depth are parametrised, the commutator and post-delay are built in, and a valid qualifier is added.
- Placed between butterfly stage n and stage n+1. Output pairs are (x[k], x[k+DELAY]) ready for the next butterfly.

Parameters:
- DATA_W, 16, bit width of each real/imag component.
- DELAY, 16, delay depth and commutator half-period in samples. Must be a power of 2 and ≥2.
- ADDR_W, $clog2(DELAY), localparam, buffer address width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  input pair valid this cycle
- bf_out0_re / bf_out0_im  in  DATA_W each  upper butterfly output
- bf_out1_re / bf_out1_im  in  DATA_W each  lower butterfly output
- out_valid  out  1  output pair valid
- cm_out0_re / cm_out0_im  out  DATA_W each  upper path to next stage
- cm_out1_re / cm_out1_im  out  DATA_W each  lower path to next stage

Behaviour:
- Reset
  - RST high at a CLK edge clears the sample counter k (ADDR_W+1 bits), the primed flag, out_valid and all cm_out* to 0.
  - Delay memories are not reset.
  - Reset mid-frame discards all buffered samples; the next accepted input is k=0.
- Sample handling
  - Only cycles with in_valid=1 advance anything; idle cycles freeze all state and leave outputs held.
  - Accepted sample with index k uses addr = k[ADDR_W-1:0] and s = k[ADDR_W].
  - k wraps modulo 2*DELAY.
- Pre-delay
  - x0 = bf_out0; x1 = mem1[addr] (old contents); same edge writes mem1[addr] <= bf_out1.
  - Delay is exactly DELAY accepted samples.
- Commutator
  - s=0: straight, c0=x0, c1=x1.
  - s=1: crossed, c0=x1, c1=x0.
- Post-delay
  - y0 = mem0[addr] (old contents); same edge writes mem0[addr] <= c0.
- Output register
  - Fires on an accepted input: cm_out0 <= y0, cm_out1 <= c1, out_valid <= primed.
  - Latency is 1 cycle after the accepted input.
  - On cycles with in_valid=0, out_valid <= 0.
- primed
  - Set on the edge accepting k=DELAY-1; stays set until RST.
  - First valid output therefore corresponds to input index DELAY.
- Read-before-write on the same address is mandatory (old data out). Both memories share addr.
- Re and im are handled identically and never mixed.
- Arithmetic: none, no width growth; data passes bit-exact.

Optional Feature:
Macro R2MDC_DC_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output in_ready (1).
  - A flush pulse while in_ready=1 drops in_ready for exactly DELAY cycles. During those cycles the block internally injects zero-valued pairs as accepted samples, so the last frame's delayed tail drains with out_valid=1.
  - in_valid is ignored while in_ready=0.
  - After the drain: k=0, primed=0, in_ready=1.
  - Flush coinciding with RST: RST wins.
- Undefined: no ports added. The tail stays buffered until pushed out by the next frame.

Decomposition:
- Shared package r2mdc_pkg:
  - DATA_W default.
  - A complex-sample struct typedef {re, im}.
  - An is_pow2 check function used for DELAY elaboration assertions.
- Sub-module dc_delay_line: DATA_W x 2 wide, DELAY-deep circular buffer with en, addr, din, read-old dout. Instantiated twice (pre-delay and post-delay).

Test Plan:
- DELAY=2, ramp a=0..7 on path0, b=100..107 on path1, in_valid continuous.
  - First out_valid 1 cycle after k=2.
  - Pairs: (0,2), (1,3), (100,102), (101,103), (4,6), (5,7), …
- DELAY=4, 3 back-to-back frames.
  - Every output pair has stride 4 (x[k], x[k+4]).
  - Counter wrap at k=7→0 produces no glitch or gap.
- DELAY=2, in_valid toggled 1-0-1-0.
  - Outputs are identical in value to the continuous case.
  - out_valid is only high the cycle after accepted inputs; outputs are held during gaps.
- RST asserted at k=3 of a DELAY=4 frame.
  - Next cycle out_valid=0 and outputs are 0.
  - The new stream restarts with its first valid output after 4 accepted samples; no pre-reset data appears.
- With R2MDC_DC_FLUSH_EN, DELAY=2, flush after 8 samples.
  - in_ready=0 for 2 cycles; remaining b-path tail (106,107 pair) emerges with out_valid=1.
  - Then in_ready=1 and primed=0.
- DATA_W=24, DELAY=16, random data.
  - Outputs match a scoreboard model bit-exact.

Source files
------------

// File: rtl/r2mdc_pkg.sv
// Shared types and elaboration helpers for the R2MDC delay-commutator.
package r2mdc_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] re;
    logic [DATA_W_DEF-1:0] im;
  } cplx_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/r2mdc_delay_commutator_if.sv
// Sample bundle between butterfly stage n and the delay-commutator feeding stage n+1.
// flush/in_ready exist only when R2MDC_DC_FLUSH_EN is defined.
interface r2mdc_delay_commutator_if import r2mdc_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] bf_out0_re;
  logic [DATA_W-1:0] bf_out0_im;
  logic [DATA_W-1:0] bf_out1_re;
  logic [DATA_W-1:0] bf_out1_im;
  logic              out_valid;
  logic [DATA_W-1:0] cm_out0_re;
  logic [DATA_W-1:0] cm_out0_im;
  logic [DATA_W-1:0] cm_out1_re;
  logic [DATA_W-1:0] cm_out1_im;

`ifdef R2MDC_DC_FLUSH_EN
  logic flush;
  logic in_ready;

  modport master (
    output in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im, flush,
    input  out_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im, in_ready
  );
  modport slave (
    input  in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im, flush,
    output out_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im, in_ready
  );
`else
  modport master (
    output in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im,
    input  out_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im
  );
  modport slave (
    input  in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im,
    output out_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im
  );
`endif

endinterface

// File: rtl/dc_delay_line.sv
// DELAY-deep circular buffer of {re,im} words; the combinational read returns
// the word stored before this cycle's write to the same address.
module dc_delay_line import r2mdc_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DELAY   = 16,
  localparam int ADDR_W = $clog2(DELAY)
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0] din_i,
  output logic [2*DATA_W-1:0] dout_o
);

  logic [2*DATA_W-1:0] mem_q [DELAY];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/r2mdc_delay_commutator.sv
// R2MDC inter-stage reorder: pre-delay lower path, commutate every DELAY samples,
// post-delay upper path; 1-cycle output register. Optional drain via R2MDC_DC_FLUSH_EN.
module r2mdc_delay_commutator import r2mdc_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DELAY  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  r2mdc_delay_commutator_if.slave  io
);

  localparam int ADDR_W = $clog2(DELAY);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } smp_t;

  if (!is_pow2(DELAY) || DELAY < 2) begin : g_bad_delay
    $error("DELAY must be a power of two and at least 2");
  end

  logic [ADDR_W:0]   k_q, k_d;
  logic              primed_q, primed_d;
  logic              out_valid_q, out_valid_d;
  smp_t              cm0_q, cm0_d, cm1_q, cm1_d;
  logic              accept;
  logic [ADDR_W-1:0] addr;
  logic              sw;
  smp_t              x0, x1, din1, c0, c1, y0;

`ifdef R2MDC_DC_FLUSH_EN
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] dcnt_q, dcnt_d;

  // While draining, zero pairs stand in for real input so the buffered tail walks out.
  assign io.in_ready = !drain_q;
  assign accept      = drain_q | io.in_valid;
  assign x0          = drain_q ? '0 : {io.bf_out0_re, io.bf_out0_im};
  assign din1        = drain_q ? '0 : {io.bf_out1_re, io.bf_out1_im};
`else
  assign accept      = io.in_valid;
  assign x0          = {io.bf_out0_re, io.bf_out0_im};
  assign din1        = {io.bf_out1_re, io.bf_out1_im};
`endif

  assign addr = k_q[ADDR_W-1:0];
  assign sw   = k_q[ADDR_W];
  assign c0   = sw ? x1 : x0;
  assign c1   = sw ? x0 : x1;

  dc_delay_line #(.DATA_W(DATA_W), .DELAY(DELAY)) u_pre (
    .clk_i  (CLK),
    .en_i   (accept),
    .addr_i (addr),
    .din_i  (din1),
    .dout_o (x1)
  );

  dc_delay_line #(.DATA_W(DATA_W), .DELAY(DELAY)) u_post (
    .clk_i  (CLK),
    .en_i   (accept),
    .addr_i (addr),
    .din_i  (c0),
    .dout_o (y0)
  );

  always_comb begin
    k_d         = k_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    cm0_d       = cm0_q;
    cm1_d       = cm1_q;
    if (accept) begin
      k_d         = k_q + (ADDR_W+1)'(1);
      out_valid_d = primed_q;
      cm0_d       = y0;
      cm1_d       = c1;
      if (k_q == (ADDR_W+1)'(DELAY-1)) begin
        primed_d = 1'b1;
      end
    end
`ifdef R2MDC_DC_FLUSH_EN
    drain_d = drain_q;
    dcnt_d  = dcnt_q;
    if (drain_q) begin
      dcnt_d = dcnt_q + ADDR_W'(1);
      if (dcnt_q == ADDR_W'(DELAY-1)) begin
        drain_d  = 1'b0;
        k_d      = '0;
        primed_d = 1'b0;
      end
    end else if (io.flush) begin
      drain_d = 1'b1;
      dcnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k_q         <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cm0_q       <= '0;
      cm1_q       <= '0;
`ifdef R2MDC_DC_FLUSH_EN
      drain_q     <= 1'b0;
      dcnt_q      <= '0;
`endif
    end else begin
      k_q         <= k_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      cm0_q       <= cm0_d;
      cm1_q       <= cm1_d;
`ifdef R2MDC_DC_FLUSH_EN
      drain_q     <= drain_d;
      dcnt_q      <= dcnt_d;
`endif
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.cm_out0_re = cm0_q.re;
  assign io.cm_out0_im = cm0_q.im;
  assign io.cm_out1_re = cm1_q.re;
  assign io.cm_out1_im = cm1_q.im;

endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// Directed bench for the delay-commutator at DELAY=2, DELAY=4 and DELAY=16/DATA_W=24.
module tb_r2mdc_delay_commutator;
  import r2mdc_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  r2mdc_delay_commutator_if #(.DATA_W(16)) if2 ();
  r2mdc_delay_commutator_if #(.DATA_W(16)) if4 ();
  r2mdc_delay_commutator_if #(.DATA_W(24)) if16 ();

  r2mdc_delay_commutator #(.DATA_W(16), .DELAY(2))  dut2  (.CLK(CLK), .RST(RST), .io(if2));
  r2mdc_delay_commutator #(.DATA_W(16), .DELAY(4))  dut4  (.CLK(CLK), .RST(RST), .io(if4));
  r2mdc_delay_commutator #(.DATA_W(24), .DELAY(16)) dut16 (.CLK(CLK), .RST(RST), .io(if16));

  logic [63:0] o2, o4;
  logic [95:0] o16;
  assign o2  = {if2.cm_out0_re, if2.cm_out0_im, if2.cm_out1_re, if2.cm_out1_im};
  assign o4  = {if4.cm_out0_re, if4.cm_out0_im, if4.cm_out1_re, if4.cm_out1_im};
  assign o16 = {if16.cm_out0_re, if16.cm_out0_im, if16.cm_out1_re, if16.cm_out1_im};

  // Hand-derived DELAY=2 output pairs for inputs a=n, b=100+n, starting at n=2.
  int t0 [6] = '{0, 1, 100, 101, 4, 5};
  int t1 [6] = '{2, 3, 102, 103, 6, 7};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cplx_t mk(input int v);
    mk.re = 16'(v);
    mk.im = 16'(v) ^ 16'h5A5A;
  endfunction

  // Reference pairing: upper half-period gives (a[n-D], a[n]), lower gives (b[n-2D], b[n-D]).
  function automatic logic [63:0] er(input int n, input int d, input int a0, input int b0);
    if ((n % (2 * d)) >= d) return {mk(a0 + n - d), mk(a0 + n)};
    else                    return {mk(b0 + n - 2 * d), mk(b0 + n - d)};
  endfunction

  task automatic d2(input logic v, input int a, input int b);
    if2.in_valid = v;
    {if2.bf_out0_re, if2.bf_out0_im} = mk(a);
    {if2.bf_out1_re, if2.bf_out1_im} = mk(b);
    @(posedge CLK); #1;
  endtask

  task automatic d4(input logic v, input int a, input int b);
    if4.in_valid = v;
    {if4.bf_out0_re, if4.bf_out0_im} = mk(a);
    {if4.bf_out1_re, if4.bf_out1_im} = mk(b);
    @(posedge CLK); #1;
  endtask

  logic [47:0] pa[$];
  logic [47:0] pb[$];
  logic [95:0] last16;
  bit          have16;
  int          n16;
  logic        v16;
  logic [47:0] r0, r1;

  initial begin
    RST = 1'b1;
    if2.in_valid = 1'b0;  if4.in_valid = 1'b0;  if16.in_valid = 1'b0;
    {if16.bf_out0_re, if16.bf_out0_im, if16.bf_out1_re, if16.bf_out1_im} = '0;
`ifdef R2MDC_DC_FLUSH_EN
    if2.flush = 1'b0;  if4.flush = 1'b0;  if16.flush = 1'b0;
`endif
    d2(0, 0, 0);
    d2(0, 0, 0);
    check("rst_vld2", if2.out_valid, 1'b0);
    check("rst_out2", o2, 64'd0);
    check("rst_vld4", if4.out_valid, 1'b0);
    check("rst_out16", o16, 96'd0);
    RST = 1'b0;

    // DELAY=2 continuous ramp
    for (int n = 0; n < 8; n++) begin
      d2(1, n, 100 + n);
      if (n < 2) check("c2_vld", if2.out_valid, 1'b0);
      else begin
        check("c2_vld", if2.out_valid, 1'b1);
        check("c2_dat", o2, {mk(t0[n-2]), mk(t1[n-2])});
      end
    end

    // DELAY=2 with idle cycles between every sample
    RST = 1'b1; d2(0, 0, 0); RST = 1'b0;
    check("g2_rst_out", o2, 64'd0);
    for (int n = 0; n < 8; n++) begin
      d2(1, n, 100 + n);
      if (n < 2) check("g2_vld", if2.out_valid, 1'b0);
      else begin
        check("g2_vld", if2.out_valid, 1'b1);
        check("g2_dat", o2, {mk(t0[n-2]), mk(t1[n-2])});
      end
      d2(0, 999, 999);
      check("g2_idle_vld", if2.out_valid, 1'b0);
      if (n >= 2) check("g2_hold", o2, {mk(t0[n-2]), mk(t1[n-2])});
    end

    // DELAY=4, three back-to-back frames across counter wraps
    for (int n = 0; n < 24; n++) begin
      d4(1, 1000 + n, 2000 + n);
      if (n < 4) check("f4_vld", if4.out_valid, 1'b0);
      else begin
        check("f4_vld", if4.out_valid, 1'b1);
        check("f4_dat", o4, er(n, 4, 1000, 2000));
      end
    end

    // Reset at k=3 of a frame, then a fresh stream
    for (int n = 24; n < 27; n++) begin
      d4(1, 1000 + n, 2000 + n);
      check("r4_pre_dat", o4, er(n, 4, 1000, 2000));
    end
    RST = 1'b1;
    d4(1, 9999, 9999);
    RST = 1'b0;
    check("r4_rst_vld", if4.out_valid, 1'b0);
    check("r4_rst_out", o4, 64'd0);
    for (int n = 0; n < 12; n++) begin
      d4(1, 4000 + n, 5000 + n);
      if (n < 4) check("r4_vld", if4.out_valid, 1'b0);
      else begin
        check("r4_vld", if4.out_valid, 1'b1);
        check("r4_dat", o4, er(n, 4, 4000, 5000));
      end
    end

    // DATA_W=24, DELAY=16, random data with random gaps
    n16 = 0;
    have16 = 1'b0;
    for (int i = 0; i < 140; i++) begin
      v16 = ($urandom_range(0, 3) != 0);
      r0  = {24'($urandom), 24'($urandom)};
      r1  = {24'($urandom), 24'($urandom)};
      if16.in_valid = v16;
      {if16.bf_out0_re, if16.bf_out0_im} = r0;
      {if16.bf_out1_re, if16.bf_out1_im} = r1;
      if (v16) begin
        pa.push_back(r0);
        pb.push_back(r1);
      end
      @(posedge CLK); #1;
      if (v16) begin
        if (n16 < 16) check("r16_vld", if16.out_valid, 1'b0);
        else begin
          check("r16_vld", if16.out_valid, 1'b1);
          last16 = ((n16 % 32) >= 16) ? {pa[n16-16], pa[n16]} : {pb[n16-32], pb[n16-16]};
          have16 = 1'b1;
          check("r16_dat", o16, last16);
        end
        n16++;
      end else begin
        check("r16_idle_vld", if16.out_valid, 1'b0);
        if (have16) check("r16_hold", o16, last16);
      end
    end

`ifdef R2MDC_DC_FLUSH_EN
    // Flush after one 8-sample frame at DELAY=2
    RST = 1'b1; d2(0, 0, 0); RST = 1'b0;
    for (int n = 0; n < 8; n++) d2(1, n, 100 + n);
    if2.flush = 1'b1;
    d2(0, 0, 0);
    if2.flush = 1'b0;
    check("fl_rdy_a", if2.in_ready, 1'b0);
    check("fl_vld_a", if2.out_valid, 1'b0);
    d2(1, 777, 777);
    check("fl_rdy_b", if2.in_ready, 1'b0);
    check("fl_vld_b", if2.out_valid, 1'b1);
    check("fl_dat_b", o2, {mk(104), mk(106)});
    d2(1, 777, 777);
    check("fl_rdy_c", if2.in_ready, 1'b1);
    check("fl_vld_c", if2.out_valid, 1'b1);
    check("fl_dat_c", o2, {mk(105), mk(107)});
    d2(1, 0, 100);
    check("fl_new_vld0", if2.out_valid, 1'b0);
    d2(1, 1, 101);
    check("fl_new_vld1", if2.out_valid, 1'b0);
    d2(1, 2, 102);
    check("fl_new_vld2", if2.out_valid, 1'b1);
    check("fl_new_dat", o2, {mk(0), mk(2)});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
